// File: rtl/pwm_dt_gen.sv
// -----------------------------------------------------------------------------
// pwm_dt_gen
//
// Complementary PWM generator for one half-bridge leg with programmable dead
// time. A prescaler clock-enable paces the period counter, so everything runs
// on clk alone. Period, duty, dead time and alignment mode are captured into
// shadow registers at each period start (and on the first enabled clk), so a
// mid-period change never produces a runt or a malformed period.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   en        run enable; 0 drives both gates low on the next clk
//   mode      0 = edge-aligned, 1 = center-aligned
//   presc     counter advances once every presc+1 clk (read live)
//   period    period value (shadowed)
//   duty      compare value (shadowed)
//   deadtime  both-low gap in clk cycles (shadowed)
//   s         high-side gate (registered)
//   nots      low-side gate (registered)
//   sync      one-clk pulse after the tick that starts a period (registered)
// -----------------------------------------------------------------------------
module pwm_dt_gen #(
    parameter int WIDTH   = 10,
    parameter int PRESC_W = 8,
    parameter int DT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   period,
    input  logic [WIDTH-1:0]   duty,
    input  logic [DT_W-1:0]    deadtime,
    output logic               s,
    output logic               nots,
    output logic               sync
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_LOW,
        ST_DT,
        ST_HIGH
    } state_t;

    // enable history: a rising en reloads the shadows before counting starts
    logic               en_q;

    // prescaler / period counter
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               dir_down_q, dir_down_d;

    // shadow registers
    logic [WIDTH-1:0]   per_a_q, duty_a_q;
    logic [DT_W-1:0]    dt_a_q;
    logic               mode_a_q;

    // compare and dead-time FSM
    logic               raw_q, raw_prev_q;
    state_t             state_q, state_d;
    logic [DT_W-1:0]    dtcnt_q, dtcnt_d;

    // registered outputs
    logic               s_q, nots_q, sync_q;

    logic               run;
    logic               tick;
    logic               pstart;
    logic               load;

    // Counting only starts one clk after en rises, so the first counted tick
    // already sees freshly loaded shadow values.
    assign run  = en & en_q;
    assign tick = run & (pcnt_q == presc);
    assign load = (en & ~en_q) | pstart;

    // -------------------------------------------------------------------------
    // Prescaler and period counter
    // -------------------------------------------------------------------------
    always_comb begin
        pcnt_d     = pcnt_q;
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        pstart     = 1'b0;

        if (!run) begin
            pcnt_d     = '0;
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else begin
            // '>=' also covers presc being lowered below the running count
            if (pcnt_q >= presc) begin
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end

            if (tick) begin
                if (!mode_a_q) begin
                    // edge-aligned sawtooth 0..per_a
                    dir_down_d = 1'b0;
                    if (cnt_q >= per_a_q) begin
                        cnt_d  = '0;
                        pstart = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // center-aligned triangle: up 0..per_a, down per_a-1..1.
                    // The period ends on the down-count step out of 1; with
                    // per_a=1 that step is the turn at the top itself, and
                    // with per_a=0 every tick is a period.
                    if ((per_a_q == '0) ||
                        (dir_down_q && (cnt_q <= CNT_ONE)) ||
                        (!dir_down_q && (per_a_q == CNT_ONE) && (cnt_q >= per_a_q))) begin
                        cnt_d      = '0;
                        dir_down_d = 1'b0;
                        pstart     = 1'b1;
                    end else if (!dir_down_q) begin
                        if (cnt_q >= per_a_q) begin
                            dir_down_d = 1'b1;
                            cnt_d      = cnt_q - 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
        end else begin
            en_q       <= en;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            dir_down_q <= dir_down_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_a_q  <= '0;
            duty_a_q <= '0;
            dt_a_q   <= '0;
            mode_a_q <= 1'b0;
        end else if (load) begin
            per_a_q  <= period;
            duty_a_q <= duty;
            dt_a_q   <= deadtime;
            mode_a_q <= mode;
        end
    end

    // -------------------------------------------------------------------------
    // Compare stage and period-start pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q      <= 1'b0;
            raw_prev_q <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            // duty_a > per_a keeps raw at 1 because cnt never exceeds per_a
            raw_q      <= run & (cnt_q < duty_a_q);
            raw_prev_q <= raw_q;
            sync_q     <= pstart;
        end
    end

    // -------------------------------------------------------------------------
    // Dead-time FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dtcnt_d = dtcnt_q;

        if (!en) begin
            state_d = ST_OFF;
            dtcnt_d = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_DT;
                    dtcnt_d = DT_ONE;
                end
                ST_LOW: begin
                    if (raw_q) begin
                        if (dt_a_q != '0) begin
                            state_d = ST_DT;
                            dtcnt_d = DT_ONE;
                        end else begin
                            state_d = ST_HIGH;
                        end
                    end
                end
                ST_HIGH: begin
                    if (!raw_q) begin
                        if (dt_a_q != '0) begin
                            state_d = ST_DT;
                            dtcnt_d = DT_ONE;
                        end else begin
                            state_d = ST_LOW;
                        end
                    end
                end
                ST_DT: begin
                    // A compare edge inside the gap restarts it, so a pulse
                    // shorter than the dead time never reaches a gate.
                    if (raw_q != raw_prev_q) begin
                        dtcnt_d = DT_ONE;
                    end else if (dtcnt_q >= dt_a_q) begin
                        state_d = raw_q ? ST_HIGH : ST_LOW;
                        dtcnt_d = '0;
                    end else begin
                        dtcnt_d = dtcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    dtcnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            dtcnt_q <= '0;
            s_q     <= 1'b0;
            nots_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dtcnt_q <= dtcnt_d;
            // Gates decoded from the next state: glitch-free, and mutually
            // exclusive because only one state drives each gate.
            s_q     <= (state_d == ST_HIGH);
            nots_q  <= (state_d == ST_LOW);
        end
    end

    assign s    = s_q;
    assign nots = nots_q;
    assign sync = sync_q;

endmodule

// File: tb/tb_pwm_dt_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_dt_gen
//
// Directed bench for pwm_dt_gen. Outputs are sampled on the falling clock
// edge; every comparison goes through check_eq and one line is printed per
// directed comparison. Gate counts over whole periods are hand-derived from
// the period, duty and dead-time settings.
// -----------------------------------------------------------------------------
module tb_pwm_dt_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] presc;
    logic [9:0] period;
    logic [9:0] duty;
    logic [7:0] deadtime;
    logic       s;
    logic       nots;
    logic       sync;

    int n_checks = 0;
    int n_errors = 0;

    pwm_dt_gen #(
        .WIDTH   (10),
        .PRESC_W (8),
        .DT_W    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .presc    (presc),
        .period   (period),
        .duty     (duty),
        .deadtime (deadtime),
        .s        (s),
        .nots     (nots),
        .sync     (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp, input bit verbose);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else if (verbose) begin
            $display("check %s: got %0d, expected %0d, ok", tag, obs, exp);
        end
    endtask

    // gate overlap is illegal in every cycle
    always @(negedge clk) begin
        check_eq("overlap", int'(s & nots), 0, 1'b0);
    end

    // count gate states over the next n samples
    task automatic measure(input int n, output int s_hi, output int n_hi,
                           output int both_lo, output int syn);
        s_hi = 0; n_hi = 0; both_lo = 0; syn = 0;
        repeat (n) begin
            @(negedge clk);
            s_hi    += int'(s);
            n_hi    += int'(nots);
            both_lo += int'(!s && !nots);
            syn     += int'(sync);
        end
    endtask

    task automatic setup(input bit m, input int pr, input int per, input int du, input int dt);
        mode     = m;
        presc    = 8'(pr);
        period   = 10'(per);
        duty     = 10'(du);
        deadtime = 8'(dt);
    endtask

    initial begin
        int sh, nh, bl, sy;
        int found;
        int lowcnt;

        rst = 1'b0;
        en  = 1'b0;
        setup(1'b0, 0, 9, 3, 2);
        #1 rst = 1'b1;
        #1;
        check_eq("reset_s",    int'(s),    0, 1'b1);
        check_eq("reset_nots", int'(nots), 0, 1'b1);
        check_eq("reset_sync", int'(sync), 0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- edge mode, per=9 duty=3 dt=2: raw high 3 of 10 clk ----
        en = 1'b1;
        repeat (40) @(negedge clk);
        measure(10, sh, nh, bl, sy);
        check_eq("edge_s_hi",   sh, 1, 1'b1);
        check_eq("edge_nots_hi", nh, 5, 1'b1);
        check_eq("edge_both_lo", bl, 4, 1'b1);
        check_eq("edge_sync",   sy, 1, 1'b1);
        measure(30, sh, nh, bl, sy);
        check_eq("edge3_s_hi",  sh, 3, 1'b1);
        check_eq("edge3_sync",  sy, 3, 1'b1);

        // ---- asynchronous reset mid-period (on the sync cycle, nots high) ----
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (sync) begin found = 1; break; end
            @(negedge clk);
        end
        check_eq("wait_sync_a", found, 1, 1'b1);
        check_eq("pre_rst_nots", int'(nots), 1, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst_s",    int'(s),    0, 1'b1);
        check_eq("midrst_nots", int'(nots), 0, 1'b1);
        check_eq("midrst_sync", int'(sync), 0, 1'b1);
        measure(3, sh, nh, bl, sy);
        check_eq("rst_hold_lo", bl, 3, 1'b1);

        // ---- duty = 0: nots constant after the initial gap ----
        setup(1'b0, 0, 9, 0, 2);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        measure(20, sh, nh, bl, sy);
        check_eq("duty0_s_hi",   sh, 0,  1'b1);
        check_eq("duty0_nots_hi", nh, 20, 1'b1);
        check_eq("duty0_sync",   sy, 2,  1'b1);

        // ---- duty > period: s constant ----
        duty = 10'd15;
        repeat (30) @(negedge clk);
        measure(20, sh, nh, bl, sy);
        check_eq("duty15_s_hi",   sh, 20, 1'b1);
        check_eq("duty15_nots_hi", nh, 0,  1'b1);

        // ---- pulse shorter than dead time is swallowed ----
        // raw high 1 clk: nots falls 1 clk after the rise and returns
        // dt+1 clk after the fall, so it is low 4 clk of every 10.
        setup(1'b0, 0, 9, 1, 3);
        repeat (40) @(negedge clk);
        measure(20, sh, nh, bl, sy);
        check_eq("short_s_hi",    sh, 0,  1'b1);
        check_eq("short_nots_hi", nh, 12, 1'b1);
        check_eq("short_both_lo", bl, 8,  1'b1);

        // ---- center mode, per=4 duty=2 presc=1: 16 clk period ----
        // raw high 3 ticks = 6 clk; s = 6-2, nots = 10-2 per period
        setup(1'b1, 1, 4, 2, 2);
        repeat (64) @(negedge clk);
        measure(32, sh, nh, bl, sy);
        check_eq("ctr_s_hi",    sh, 8,  1'b1);
        check_eq("ctr_nots_hi", nh, 16, 1'b1);
        check_eq("ctr_both_lo", bl, 8,  1'b1);
        check_eq("ctr_sync",    sy, 2,  1'b1);

        // ---- shadowing: duty 3 -> 7 right after a period start ----
        setup(1'b0, 0, 9, 3, 2);
        repeat (40) @(negedge clk);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (sync) begin found = 1; break; end
            @(negedge clk);
        end
        check_eq("wait_sync_b", found, 1, 1'b1);
        duty = 10'd7;
        measure(10, sh, nh, bl, sy);
        check_eq("shadow_cur_s_hi", sh, 1, 1'b1);
        check_eq("shadow_cur_sync", sy, 1, 1'b1);
        measure(10, sh, nh, bl, sy);
        check_eq("shadow_next_s_hi", sh, 5, 1'b1);
        check_eq("shadow_next_sync", sy, 1, 1'b1);

        // ---- dt = 0: s is the exact inverse of nots ----
        deadtime = 8'd0;
        duty     = 10'd3;
        repeat (30) @(negedge clk);
        measure(20, sh, nh, bl, sy);
        check_eq("dt0_both_lo", bl, 0,  1'b1);
        check_eq("dt0_s_hi",    sh, 6,  1'b1);
        check_eq("dt0_nots_hi", nh, 14, 1'b1);

        // ---- enable toggle during HIGH ----
        deadtime = 8'd2;
        duty     = 10'd7;
        repeat (30) @(negedge clk);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (s) begin found = 1; break; end
            @(negedge clk);
        end
        check_eq("wait_high", found, 1, 1'b1);
        en = 1'b0;
        @(negedge clk);
        check_eq("dis_s",    int'(s),    0, 1'b1);
        check_eq("dis_nots", int'(nots), 0, 1'b1);
        check_eq("dis_sync", int'(sync), 0, 1'b1);
        measure(5, sh, nh, bl, sy);
        check_eq("dis_hold_lo", bl, 5, 1'b1);
        check_eq("dis_hold_sync", sy, 0, 1'b1);

        en = 1'b1;
        found  = 0;
        lowcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s || nots) begin found = 1; break; end
            lowcnt++;
        end
        check_eq("reen_found", found, 1, 1'b1);
        check_eq("reen_gap_ge_dt", int'(lowcnt >= 2), 1, 1'b1);
        check_eq("reen_first_s",    int'(s),    1, 1'b1);
        check_eq("reen_first_nots", int'(nots), 0, 1'b1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
